// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Recomputes XOR parity and reports each frame with parity/framing error flags.
module serial_parity_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              rx_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic [CNT_W-1:0]    cnt_q,        cnt_d;
  logic [DATA_W-1:0]   shift_q,      shift_d;
  logic                acc_q,        acc_d;
  logic                perr_q,       perr_d;
  logic                ferr_q,       ferr_d;
  logic                report_q,     report_d;
  logic [DATA_W-1:0]   data_out_q,   data_out_d;
  logic                data_valid_q, data_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q,  frame_err_d;
  logic                busy_q,       busy_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      report_q     <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      report_q     <= report_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  // Next-state logic; the frame is published one edge after the stop strobe
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    report_d     = 1'b0;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    // A start bit may be accepted in this same cycle; it never touches shift_q
    if (report_q) begin
      data_valid_d = 1'b1;
      data_out_d   = shift_q;
      parity_err_d = perr_q;
      frame_err_d  = ferr_q;
    end

    if (sample_en) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_bit) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_d   = ODD_PARITY;
          end
        end
        DATA: begin
          shift_d = (shift_q >> 1) | (DATA_W'(rx_bit) << (DATA_W - 1));
          acc_d   = acc_q ^ rx_bit;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          perr_d  = acc_q ^ rx_bit;
          state_d = STOP;
        end
        STOP: begin
          ferr_d   = ~rx_bit;
          report_d = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Bench for serial_parity_rx: even and odd parity instances share one line;
// a scoreboard queue holds the expected report of every complete frame.
module tb_serial_parity_rx;

  localparam int unsigned DW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          pe;
    logic          po;
    logic          fe;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_en = 1'b0;
  logic rx_bit = 1'b1;

  logic [DW-1:0] dout_e, dout_o;
  logic dv_e, dv_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  exp_t exp_q[$];
  exp_t held;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_dv = 0;
  int   n_pushed = 0;
  int   cyc = 0;
  int   last_dv = 0;
  int   prev_dv = 0;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(DW), .ODD_PARITY(1'b0)) u_even (
    .clk(clk), .rst(rst), .sample_en(sample_en), .rx_bit(rx_bit),
    .data_out(dout_e), .data_valid(dv_e), .parity_err(perr_e),
    .frame_err(ferr_e), .busy(busy_e)
  );

  serial_parity_rx #(.DATA_W(DW), .ODD_PARITY(1'b1)) u_odd (
    .clk(clk), .rst(rst), .sample_en(sample_en), .rx_bit(rx_bit),
    .data_out(dout_o), .data_valid(dv_o), .parity_err(perr_o),
    .frame_err(ferr_o), .busy(busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      held = '{data: '0, pe: 1'b0, po: 1'b0, fe: 1'b0};
      check_eq("rst_dout_e", 32'(dout_e), 0);
      check_eq("rst_dout_o", 32'(dout_o), 0);
      check_eq("rst_dv", 32'({dv_e, dv_o}), 0);
      check_eq("rst_err", 32'({perr_e, ferr_e, perr_o, ferr_o}), 0);
      check_eq("rst_busy", 32'({busy_e, busy_o}), 0);
    end else if (dv_e || dv_o) begin
      n_dv++;
      prev_dv = last_dv;
      last_dv = cyc;
      check_eq("dv_pair", 32'(dv_o), 32'(dv_e));
      if (exp_q.size() == 0) begin
        check_eq("unexpected_dv", 1, 0);
      end else begin
        held = exp_q.pop_front();
        check_eq("data_e", 32'(dout_e), 32'(held.data));
        check_eq("data_o", 32'(dout_o), 32'(held.data));
        check_eq("perr_even", 32'(perr_e), 32'(held.pe));
        check_eq("perr_odd", 32'(perr_o), 32'(held.po));
        check_eq("ferr_e", 32'(ferr_e), 32'(held.fe));
        check_eq("ferr_o", 32'(ferr_o), 32'(held.fe));
      end
    end else begin
      check_eq("hold_data", 32'({dout_e, dout_o}), 32'({held.data, held.data}));
      check_eq("hold_flags", 32'({perr_e, perr_o, ferr_e, ferr_o}),
               32'({held.pe, held.po, held.fe, held.fe}));
    end
  end

  task automatic strobe(input logic b, input int gap_max);
    int g;
    g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    for (int k = 0; k < g; k++) begin
      sample_en = 1'b0;
      @(posedge clk); #1;
    end
    sample_en = 1'b1;
    rx_bit    = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    sample_en = 1'b0;
    rx_bit    = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] data, input logic p,
                            input logic stop, input int gap_max);
    exp_t e;
    e.data = data;
    e.pe   = (^data) ^ p;
    e.po   = ~((^data) ^ p);
    e.fe   = ~stop;
    exp_q.push_back(e);
    n_pushed++;
    strobe(1'b0, gap_max);
    for (int i = 0; i < int'(DW); i++) strobe(data[i], gap_max);
    strobe(p, gap_max);
    strobe(stop, gap_max);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Clean even-parity frame, then parity error, then error clears
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    idle(3);
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    idle(2);
    send_frame(8'h3C, 1'b0, 1'b1, 0);
    idle(3);

    // Framing error, then idle-level strobes are ignored
    send_frame(8'h81, 1'b0, 1'b0, 0);
    idle(2);
    saved = n_dv;
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1, 0);
      check_eq("busy_on_ones", 32'({busy_e, busy_o}), 0);
    end
    idle(3);
    check_eq("no_dv_on_ones", n_dv, saved);

    // Back-to-back frames at one bit per clock
    saved = n_dv;
    send_frame(8'h00, 1'b0, 1'b1, 0);
    send_frame(8'hFF, 1'b0, 1'b1, 0);
    idle(3);
    check_eq("b2b_count", n_dv - saved, 2);
    check_eq("b2b_spacing", last_dv - prev_dv, 11);

    // Reset in the middle of a frame
    saved = n_dv;
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(i[0], 0);
    check_eq("busy_mid_frame", 32'({busy_e, busy_o}), 32'b11);
    rst = 1'b1;
    #2;
    check_eq("async_rst_dout", 32'(dout_e), 0);
    check_eq("async_rst_busy", 32'(busy_e), 0);
    idle(2);
    rst = 1'b0;
    idle(2);
    check_eq("no_dv_partial", n_dv, saved);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    idle(3);

    // Odd-parity cases, then the same traffic with random strobe gaps
    send_frame(8'h01, 1'b0, 1'b1, 0);
    idle(2);
    send_frame(8'h01, 1'b1, 1'b1, 0);
    idle(2);
    send_frame(8'h01, 1'b0, 1'b1, 5);
    idle(1);
    send_frame(8'h01, 1'b1, 1'b1, 5);
    for (int i = 0; i < 6; i++) begin
      send_frame(8'($urandom), 1'($urandom), 1'($urandom), 5);
      idle(int'($urandom_range(3, 0)));
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    idle(2);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("dv_count", n_dv, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
